cpl_serie: RTL and testbench

//   Parametrised, sequential successor to the combinational 4-bit ones'-complement stage.

---
 rtl/cpl_serie.sv | 122 ++++++++++++
 tb/tb_cpl_serie.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cpl_serie.sv
// cpl_serie: bit-serial pass / ones' / two's complement / absolute-value converter.
// Processes one operand bit per clock, LSB first, with a start/busy/done handshake.
module cpl_serie #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] Ent,
  output logic [WIDTH-1:0] Sal,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] M_PASS = 2'b00;
  localparam logic [1:0] M_C1   = 2'b01;
  localparam logic [1:0] M_C2   = 2'b10;
  localparam logic [1:0] M_ABS  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] opr, opr_n;     // latched operand, shifted right each bit cycle
  logic [WIDTH-1:0] res, res_n;     // partial result, filled from the MSB side
  logic [CW-1:0]    cnt, cnt_n;
  logic             seen1, seen1_n;
  logic [1:0]       emode, emode_n; // effective mode (ABS resolved at accept)
  logic [WIDTH-1:0] sal_n;
  logic             ovf_n, busy_n, done_n;
  logic             bit_r;

  // Next-state, datapath and output decode
  always_comb begin
    state_n = state;
    opr_n   = opr;
    res_n   = res;
    cnt_n   = cnt;
    seen1_n = seen1;
    emode_n = emode;
    sal_n   = Sal;
    ovf_n   = ovf;
    bit_r   = opr[0];

    case (emode)
      M_C1:    bit_r = ~opr[0];
      M_C2:    bit_r = seen1 ? ~opr[0] : opr[0];
      default: bit_r = opr[0];
    endcase

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_SHIFT;
          opr_n   = Ent;
          res_n   = '0;
          cnt_n   = '0;
          seen1_n = 1'b0;
          if (mode == M_ABS) begin
            emode_n = Ent[WIDTH-1] ? M_C2 : M_PASS;
          end else begin
            emode_n = mode;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SHIFT: begin
        opr_n   = {1'b0, opr[WIDTH-1:1]};
        res_n   = {bit_r, res[WIDTH-1:1]};
        seen1_n = seen1 | opr[0];
        cnt_n   = cnt + CW'(1);
        if (cnt == LAST_BIT) begin
          state_n = S_DONE;
          sal_n   = {bit_r, res[WIDTH-1:1]};
          // Only 100..0 reaches the MSB with no earlier 1 and a 1 in the MSB
          ovf_n   = (emode == M_C2) && !seen1 && opr[0];
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_SHIFT);
    done_n = (state_n == S_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      opr   <= '0;
      res   <= '0;
      cnt   <= '0;
      seen1 <= 1'b0;
      emode <= M_PASS;
      Sal   <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      opr   <= opr_n;
      res   <= res_n;
      cnt   <= cnt_n;
      seen1 <= seen1_n;
      emode <= emode_n;
      Sal   <= sal_n;
      ovf   <= ovf_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_cpl_serie.sv
// tb_cpl_serie: scoreboard bench for cpl_serie with an arithmetic reference model.
module tb_cpl_serie;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] ent = '0;
  logic [W-1:0] sal;
  logic         busy, done, ovf;

  cpl_serie #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .Ent(ent),
    .Sal(sal), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  logic [W:0] exp_q[$];   // {ovf, Sal}
  int         cyc_q[$];   // cycle count right after the accept edge

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tot++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference model: plain modular arithmetic on the whole word
  function automatic logic [W:0] ref_conv(input logic [1:0] m, input logic [W-1:0] e);
    logic [W-1:0] r;
    logic         neg_mode;
    neg_mode = (m == 2'b10) || (m == 2'b11 && e >= W'(1 << (W - 1)));
    if (m == 2'b00)      r = e;
    else if (m == 2'b01) r = W'(2 ** W - 1) - e;
    else if (neg_mode)   r = W'(2 ** W - int'(e));
    else                 r = e;
    return {neg_mode && (e == W'(1 << (W - 1))), r};
  endfunction

  logic [W-1:0] last_sal = '0;
  logic         last_ovf = 1'b0;
  int           busy_run = 0;

  // Monitor: pops the scoreboard on each done pulse, checks holds otherwise
  always @(negedge clk) begin : monitor
    logic [W:0] e;
    int         c;
    if (reset) begin
      last_sal = '0;
      last_ovf = 1'b0;
      busy_run = 0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("sal", 32'(sal), 32'(e[W-1:0]));
        check("ovf", 32'(ovf), 32'(e[W]));
        check("done_latency", 32'(cyc), 32'(c + int'(W)));
        last_sal = e[W-1:0];
        last_ovf = e[W];
      end
      check("busy_cycles", 32'(busy_run), 32'(W));
      check("busy_in_done", 32'(busy), 32'(0));
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      check("sal_hold", 32'(sal), 32'(last_sal));
      check("ovf_hold", 32'(ovf), 32'(last_ovf));
    end
  end

  // Drive start at the current time (caller is at a negedge), push expectation,
  // then scribble inputs while the conversion runs.
  task automatic issue(input logic [1:0] m, input logic [W-1:0] e, input bit wait_done);
    bit seen;
    seen  = 1'b0;
    start = 1'b1;
    mode  = m;
    ent   = e;
    @(posedge clk);
    #1;
    exp_q.push_back(ref_conv(m, e));
    cyc_q.push_back(cyc);
    start = 1'b0;
    mode  = 2'($urandom);
    ent   = W'($urandom);
    if (wait_done) begin
      for (int i = 0; i < 3 * int'(W) && !seen; i++) begin
        @(negedge clk);
        start = 1'b0;
        if (done) begin
          seen = 1'b1;
        end else begin
          start = 1'($urandom % 2);
          mode  = 2'($urandom);
          ent   = W'($urandom);
        end
      end
      check("done_timeout", 32'(seen), 32'(1));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_sal", 32'(sal), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    @(negedge clk);

    issue(2'b01, 8'h5A, 1); @(negedge clk);
    issue(2'b10, 8'h01, 1); @(negedge clk);
    issue(2'b10, 8'h00, 1); @(negedge clk);
    issue(2'b10, 8'h80, 1); @(negedge clk);
    issue(2'b11, 8'h80, 1); @(negedge clk);
    issue(2'b11, 8'hF6, 1); @(negedge clk);
    issue(2'b11, 8'h35, 1); @(negedge clk);
    issue(2'b00, 8'hC3, 1); @(negedge clk);
    issue(2'b01, 8'h0F, 1); @(negedge clk);

    // back-to-back: start held in the DONE cycle
    issue(2'b10, 8'h80, 1);
    issue(2'b11, 8'hF6, 1);
    issue(2'b01, 8'h33, 1);
    @(negedge clk);

    // reset in the middle of a conversion discards it
    issue(2'b10, 8'h12, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_sal", 32'(sal), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_ovf", 32'(ovf), 32'(0));
    void'(exp_q.pop_back());
    void'(cyc_q.pop_back());
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (W + 4) @(negedge clk);
    issue(2'b10, 8'h12, 1); @(negedge clk);

    // random traffic, sometimes back-to-back
    for (int k = 0; k < 150; k++) begin
      if ($urandom % 2 == 0) @(negedge clk);
      issue(2'($urandom), W'($urandom), 1);
    end

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
